window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/img_pkg.sv | 6 +
 rtl/line_buffer.sv | 20 ++
 rtl/window_3x3_gen.sv | 127 ++++++++++++
 tb/tb_window_3x3_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline constants used by the window generator and the Kirsch edge stages.
package img_pkg;
  localparam int unsigned PIX_W_DEF      = 8;
  localparam int unsigned IMG_WIDTH_DEF  = 64;
  localparam int unsigned IMG_HEIGHT_DEF = 64;
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: combinational read at idx, registered write at idx.
module line_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [PIX_W-1:0]         din,
  output logic [PIX_W-1:0]         dout
);
  logic [PIX_W-1:0] mem_q [DEPTH];

  assign dout = mem_q[idx];

  // Contents are never reset; unread until two full rows have been rewritten.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= din;
  end
endmodule

// File: rtl/window_3x3_gen.sv
// Raster-scan 3x3 window generator: two line buffers plus a shifting register window,
// presenting only fully interior windows one cycle after the bottom-right pixel arrives.
module window_3x3_gen
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned PIX_W      = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] p9,
  output logic             out_valid,
  output logic             frame_done
);
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [PIX_W-1:0] p_q [9];
  logic [PIX_W-1:0] p_d [9];
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             last_col, last_row, win_ok;

  // lb0 holds the previous row, lb1 the row before that; lb1 is fed from lb0's old value.
  line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
    .clk  (clk),
    .we   (in_valid),
    .idx  (cur_col),
    .din  (pix_in),
    .dout (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
    .clk  (clk),
    .we   (in_valid),
    .idx  (cur_col),
    .din  (lb0_rd),
    .dout (lb1_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    p_d          = p_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    // frame_start forces this pixel to (0,0) before it is used anywhere.
    cur_col  = frame_start ? '0 : col_q;
    cur_row  = frame_start ? '0 : row_q;
    last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
    last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    win_ok   = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    if (in_valid) begin
      col_d = last_col ? '0 : cur_col + COL_W'(1);
      if (last_col) row_d = last_row ? '0 : cur_row + ROW_W'(1);
      else          row_d = cur_row;

      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = pix_in;

      if (win_ok) begin
        out_valid_d  = 1'b1;
        frame_done_d = last_col && last_row;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            p_d[r*3 + c] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      p_q          <= p_d;
    end
  end

  assign p1         = p_q[0];
  assign p2         = p_q[1];
  assign p3         = p_q[2];
  assign p4         = p_q[3];
  assign p5         = p_q[4];
  assign p6         = p_q[5];
  assign p7         = p_q[6];
  assign p8         = p_q[7];
  assign p9         = p_q[8];
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen: a 4x4 instance for directed frames and a 64x64 instance for random frames.
module tb_window_3x3_gen;
  typedef struct packed {
    logic [71:0] win;
    logic        fd;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  int unsigned cyc = 0;
  logic        rst_e = 1'b1;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= rst;
  end

  logic       fs_a = 1'b0, iv_a = 1'b0;
  logic [7:0] px_a = '0;
  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic       ov_a, fd_a;
  logic       fs_b = 1'b0, iv_b = 1'b0;
  logic [7:0] px_b = '0;
  logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic       ov_b, fd_b;

  window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) dut_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .in_valid(iv_a), .pix_in(px_a),
    .p1(a1), .p2(a2), .p3(a3), .p4(a4), .p5(a5), .p6(a6), .p7(a7), .p8(a8), .p9(a9),
    .out_valid(ov_a), .frame_done(fd_a)
  );

  window_3x3_gen #(.IMG_WIDTH(64), .IMG_HEIGHT(64), .PIX_W(8)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .in_valid(iv_b), .pix_in(px_b),
    .p1(b1), .p2(b2), .p3(b3), .p4(b4), .p5(b5), .p6(b6), .p7(b7), .p8(b8), .p9(b9),
    .out_valid(ov_b), .frame_done(fd_b)
  );

  wire [71:0] win_a = {a1, a2, a3, a4, a5, a6, a7, a8, a9};
  wire [71:0] win_b = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

  exp_t        q_a[$], q_b[$];
  logic [71:0] got_a[$];
  int          fdc_a = 0, wc_b = 0, fdc_b = 0;
  logic [71:0] prev_a = '0, prev_b = '0;
  logic [7:0]  img_a [4][4];
  logic [7:0]  img_b [64][64];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor for the 4x4 instance: pop and compare on out_valid, otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_e) begin
      if (ov_a) begin
        if (q_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_spurious: out_valid with window %h, none expected", win_a);
        end else begin
          e = q_a.pop_front();
          chk("a_window", win_a, e.win);
          chk("a_frame_done", 72'(fd_a), 72'(e.fd));
          chk("a_latency_cycle", 72'(cyc), 72'(e.cyc));
        end
        got_a.push_back(win_a);
        if (fd_a) fdc_a++;
      end else begin
        chk("a_hold", win_a, prev_a);
        chk("a_fd_without_valid", 72'(fd_a), 72'(0));
      end
    end
    prev_a = win_a;
  end

  // Monitor for the 64x64 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_e) begin
      if (ov_b) begin
        if (q_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_spurious: out_valid with window %h, none expected", win_b);
        end else begin
          e = q_b.pop_front();
          chk("b_window", win_b, e.win);
          chk("b_frame_done", 72'(fd_b), 72'(e.fd));
          chk("b_latency_cycle", 72'(cyc), 72'(e.cyc));
        end
        wc_b++;
        if (fd_b) fdc_b++;
      end else begin
        chk("b_hold", win_b, prev_b);
        chk("b_fd_without_valid", 72'(fd_b), 72'(0));
      end
    end
    prev_b = win_b;
  end

  // Accept one pixel at (r,c); the reference window is read straight out of the image array.
  task automatic pix_a(input logic fs, input int r, input int c, input logic [7:0] v);
    exp_t e;
    @(posedge clk); #1;
    fs_a = fs; iv_a = 1'b1; px_a = v;
    img_a[r][c] = v;
    if (r >= 2 && c >= 2) begin
      e.win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win = {e.win[63:0], img_a[r-2+i][c-2+j]};
      e.fd  = (r == 3 && c == 3);
      e.cyc = cyc + 1;
      q_a.push_back(e);
    end
  endtask

  task automatic gap_a(input logic fs);
    @(posedge clk); #1;
    fs_a = fs; iv_a = 1'b0; px_a = 8'($urandom);
  endtask

  task automatic frame_a(input int base, input bit gaps, input bit fs_first);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        pix_a(fs_first && r == 0 && c == 0, r, c, 8'(base + r*16 + c));
        if (gaps) gap_a(1'($urandom_range(0, 1)));
      end
  endtask

  task automatic partial_a(input int n);
    for (int k = 0; k < n; k++) pix_a(k == 0, k / 4, k % 4, 8'((k / 4) * 16 + k % 4));
  endtask

  task automatic drain_a(input string nm);
    gap_a(1'b0);
    for (int i = 0; i < 10 && q_a.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk(nm, 72'(q_a.size()), 72'(0));
  endtask

  // One-cycle reset, outputs of both instances checked while reset has taken effect.
  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    rst = 1'b1; iv_a = 1'b0; fs_a = 1'b0; iv_b = 1'b0; fs_b = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    @(negedge clk);
    chk({nm, "_a_win"}, win_a, 72'(0));
    chk({nm, "_a_flags"}, 72'({ov_a, fd_a}), 72'(0));
    chk({nm, "_b_win"}, win_b, 72'(0));
    chk({nm, "_b_flags"}, 72'({ov_b, fd_b}), 72'(0));
  endtask

  task automatic new_test();
    got_a.delete();
    fdc_a = 0;
  endtask

  initial begin
    exp_t e;
    int   r, c;
    repeat (3) @(posedge clk);
    do_reset("reset_state");

    new_test();
    frame_a(0, 1'b0, 1'b1);
    drain_a("plain_drain");
    chk("plain_windows", 72'(got_a.size()), 72'(4));
    chk("plain_frame_done", 72'(fdc_a), 72'(1));
    if (got_a.size() == 4) begin
      chk("plain_first", got_a[0], 72'h00_01_02_10_11_12_20_21_22);
      chk("plain_last", got_a[3], 72'h11_12_13_21_22_23_31_32_33);
    end

    new_test();
    frame_a(0, 1'b1, 1'b1);
    drain_a("gaps_drain");
    chk("gaps_windows", 72'(got_a.size()), 72'(4));
    chk("gaps_frame_done", 72'(fdc_a), 72'(1));

    new_test();
    frame_a(0, 1'b0, 1'b1);
    frame_a(8'h80, 1'b0, 1'b0);
    drain_a("b2b_drain");
    chk("b2b_windows", 72'(got_a.size()), 72'(8));
    chk("b2b_frame_done", 72'(fdc_a), 72'(2));
    if (got_a.size() == 8) chk("b2b_frame2_first", got_a[4], 72'h80_81_82_90_91_92_a0_a1_a2);

    new_test();
    partial_a(10);
    do_reset("midframe_reset");
    frame_a(0, 1'b0, 1'b0);
    drain_a("reset_drain");
    chk("reset_windows", 72'(got_a.size()), 72'(4));
    if (got_a.size() != 0) chk("reset_first", got_a[0], 72'h00_01_02_10_11_12_20_21_22);

    new_test();
    partial_a(8);
    frame_a(0, 1'b0, 1'b1);
    drain_a("abort_drain");
    chk("abort_windows", 72'(got_a.size()), 72'(4));
    chk("abort_frame_done", 72'(fdc_a), 72'(1));

    // Random 64x64 frame with random gaps; gap cycles may carry an ignored frame_start.
    wc_b = 0; fdc_b = 0;
    r = 0; c = 0;
    while (r < 64) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        iv_b = 1'b0; fs_b = 1'($urandom_range(0, 1)); px_b = 8'($urandom);
      end else begin
        iv_b = 1'b1; fs_b = (r == 0 && c == 0); px_b = 8'($urandom);
        img_b[r][c] = px_b;
        if (r >= 2 && c >= 2) begin
          e.win = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.win = {e.win[63:0], img_b[r-2+i][c-2+j]};
          e.fd  = (r == 63 && c == 63);
          e.cyc = cyc + 1;
          q_b.push_back(e);
        end
        c++;
        if (c == 64) begin c = 0; r++; end
      end
    end
    @(posedge clk); #1;
    iv_b = 1'b0; fs_b = 1'b0;
    for (int i = 0; i < 10 && q_b.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("rand_drain", 72'(q_b.size()), 72'(0));
    chk("rand_windows", 72'(wc_b), 72'(3844));
    chk("rand_frame_done", 72'(fdc_b), 72'(1));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
